// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: request size codes,
// response fault codes, controller state encoding and the store/load
// byte-enable pattern helper.
package mau_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] FLT_NONE  = 2'b00;
   localparam logic [1:0] FLT_ALIGN = 2'b01;
   localparam logic [1:0] FLT_RANGE = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   // Byte lanes touched by an aligned access of the given size at the given
   // byte offset within the word.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mau_lane_ext.sv
// Load lane selection and sign/zero extension.
// Ports:
//   i_dout     - raw 32-bit word read from data memory
//   i_offset   - byte offset of the access within the word (assumed aligned)
//   i_size     - access size code
//   i_unsigned - 1 = zero-extend, 0 = sign-extend
//   o_data     - right-justified, extended load result
module mau_lane_ext
   import mau_pkg::*;
(
   input  logic [31:0] i_dout,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_dout[7:0];
      case (i_offset)
         2'd0: w_byte = i_dout[7:0];
         2'd1: w_byte = i_dout[15:8];
         2'd2: w_byte = i_dout[23:16];
         2'd3: w_byte = i_dout[31:24];
         default: w_byte = i_dout[7:0];
      endcase
      // Halves are only legal at offsets 0 and 2, so offset[1] picks the lane.
      w_half = i_offset[1] ? i_dout[31:16] : i_dout[15:0];
   end

   always_comb begin
      o_data = i_dout;
      case (i_size)
         SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
         default: o_data = i_dout;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of the data memory. Takes one request at a time,
// checks alignment and range, performs a single-cycle dm access and returns
// the load result or a fault code over a valid/ready response channel.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   req_valid/req_ready             - request handshake
//   req_we/size/unsigned/addr/wdata - request fields
//   resp_valid/resp_ready           - response handshake
//   resp_rdata/resp_fault           - response payload
//   dm_we/be/addr/din, dm_dout      - data memory interface
//
// state  | meaning
// IDLE   | ready for a request; fault check on the incoming request
// ACCESS | single dm cycle: write strobes or load capture
// RESP   | response held until the core accepts it
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = 7
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_fault,
   output logic              dm_we,
   output logic [3:0]        dm_be,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_din,
   input  logic [31:0]       dm_dout
);

   state_t              r_state, w_state_nxt;
   logic                r_we;
   logic [1:0]          r_size;
   logic                r_uns;
   logic [1:0]          r_off;
   logic [ADDR_W-1:0]   r_dm_addr;
   logic [31:0]         r_dm_din;
   logic [31:0]         r_resp_rdata;
   logic [1:0]          r_resp_fault;
   logic [1:0]          w_fault;
   logic                w_accept;
   logic [31:0]         w_ld_data;

   // Alignment outranks range.
   always_comb begin
      w_fault = FLT_NONE;
      if ((req_size == 2'b11) ||
          (req_size == SZ_HALF && req_addr[0]) ||
          (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
         w_fault = FLT_ALIGN;
      else if (req_addr[31:ADDR_W+2] != '0)
         w_fault = FLT_RANGE;
   end

   assign w_accept = req_valid && (r_state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      dm_be       = 4'b0000;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_state_nxt = (w_fault != FLT_NONE) ? RESP : ACCESS;
         end
         ACCESS: begin
            dm_be       = byte_en(r_size, r_off);
            w_state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Gate with rst so a store colliding with reset never reaches memory.
   assign dm_we = (r_state == ACCESS) && r_we && !rst;

   mau_lane_ext u_lane_ext (
      .i_dout     (dm_dout),
      .i_offset   (r_off),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .o_data     (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_we         <= 1'b0;
         r_size       <= SZ_BYTE;
         r_uns        <= 1'b0;
         r_off        <= 2'b00;
         r_dm_addr    <= '0;
         r_dm_din     <= '0;
         r_resp_rdata <= '0;
         r_resp_fault <= FLT_NONE;
      end else begin
         if (w_accept) begin
            r_we         <= req_we;
            r_size       <= req_size;
            r_uns        <= req_unsigned;
            r_off        <= req_addr[1:0];
            r_resp_rdata <= '0;
            r_resp_fault <= w_fault;
            // A faulting request never touches dm, so its address/data lines keep their last values.
            if (w_fault == FLT_NONE) begin
               r_dm_addr <= req_addr[ADDR_W+1:2];
               r_dm_din  <= req_wdata;
            end
         end
         if (r_state == ACCESS)
            r_resp_rdata <= r_we ? 32'h0 : w_ld_data;
      end
   end

   assign dm_addr    = r_dm_addr;
   assign dm_din     = r_dm_din;
   assign resp_rdata = r_resp_rdata;
   assign resp_fault = r_resp_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int AW = 7;
   localparam int NWORDS = 1 << AW;
   localparam int NBYTES = NWORDS * 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_rdata;
   logic [1:0]    resp_fault;
   logic          dm_we;
   logic [3:0]    dm_be;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_din;
   logic [31:0]   dm_dout;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_fault   (resp_fault),
      .dm_we        (dm_we),
      .dm_be        (dm_be),
      .dm_addr      (dm_addr),
      .dm_din       (dm_din),
      .dm_dout      (dm_dout)
   );

   // Data memory: enabled lanes are filled from the low lanes of din in order.
   logic [31:0] dm_mem [NWORDS];
   int          wr_count = 0;

   assign dm_dout = dm_mem[dm_addr];

   always @(posedge clk) begin
      if (dm_we) begin
         int j;
         j = 0;
         for (int k = 0; k < 4; k++) begin
            if (dm_be[k]) begin
               dm_mem[dm_addr][8*k +: 8] <= dm_din[8*j +: 8];
               j++;
            end
         end
         wr_count <= wr_count + 1;
      end
   end

   // Reference model: flat byte-addressed memory.
   logic [7:0]  ref_mem [NBYTES];
   int          exp_wr = 0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int n_hold);
      logic [1:0]  flt;
      int          nb;
      logic [3:0]  be;
      logic [31:0] v;
      int          base;
      flt = 2'b00;
      if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00))
         flt = 2'b01;
      else if (addr >= NBYTES)
         flt = 2'b10;
      nb   = (size == 2'd3) ? 0 : (1 << int'(size));
      be   = 4'(((1 << nb) - 1) << int'(addr[1:0]));
      base = int'(addr[8:0]);
      v    = 32'h0;
      if (flt == 2'b00 && !we) begin
         for (int b = 0; b < nb; b++) v = v | (32'(ref_mem[base + b]) << (8 * b));
         if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      end

      chk("req_ready_idle", req_ready, 1'b1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      resp_ready   = (n_hold == 0);
      @(posedge clk); #1;
      // Junk on the request bus must be ignored while busy.
      req_valid    = $urandom_range(0, 1) == 1;
      req_we       = $urandom_range(0, 1) == 1;
      req_size     = 2'($urandom_range(0, 3));
      req_addr     = $urandom;
      req_wdata    = $urandom;

      if (flt != 2'b00) begin
         chk("flt_dm_we", dm_we, 1'b0);
      end else begin
         chk("acc_dm_we", dm_we, we);
         chk("acc_dm_be", dm_be, be);
         chk("acc_dm_addr", dm_addr, addr[8:2]);
         if (we) chk("acc_dm_din", dm_din, wdata);
         chk("acc_resp_valid", resp_valid, 1'b0);
         @(posedge clk); #1;
         if (we) begin
            for (int b = 0; b < nb; b++) ref_mem[base + b] = wdata[8*b +: 8];
            exp_wr++;
         end
      end
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_fault", resp_fault, flt);
      chk("resp_rdata", resp_rdata, v);
      chk("resp_req_ready", req_ready, 1'b0);
      chk("resp_dm_we", dm_we, 1'b0);
      last_rdata = resp_rdata;
      for (int h = 0; h < n_hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", resp_valid, 1'b1);
         chk("hold_rdata", resp_rdata, v);
         chk("hold_fault", resp_fault, flt);
         chk("hold_req_ready", req_ready, 1'b0);
      end
      resp_ready = 1'b1;
      req_valid  = 1'b0;
      @(posedge clk); #1;
      chk("back_idle_ready", req_ready, 1'b1);
      chk("back_idle_valid", resp_valid, 1'b0);
      chk("write_count", wr_count, exp_wr);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1'b1);
      chk({tag, "_resp_valid"}, resp_valid, 1'b0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_resp_fault"}, resp_fault, 2'b00);
      chk({tag, "_dm_we"}, dm_we, 1'b0);
      chk({tag, "_dm_be"}, dm_be, 4'b0000);
      chk({tag, "_dm_addr"}, dm_addr, '0);
      chk({tag, "_dm_din"}, dm_din, 32'h0);
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      for (int w = 0; w < NWORDS; w++) dm_mem[w] = 32'h0;
      for (int b = 0; b < NBYTES; b++) ref_mem[b] = 8'h0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 0);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
      chk("const_ld_word", last_rdata, 32'h1234_5678);
      do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB, 0);
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
      chk("const_ld_sbyte", last_rdata, 32'hFFFF_FFAB);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
      chk("const_ld_ubyte", last_rdata, 32'h0000_00AB);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
      chk("const_ld_merged", last_rdata, 32'hAB34_5678);
      do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 0);
      do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
      chk("const_ld_shalf", last_rdata, 32'hFFFF_8001);
      do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0);
      chk("const_ld_uhalf", last_rdata, 32'h0000_8001);

      do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0);
      do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 0);
      do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'hDEAD_BEEF, 0);
      do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFE_F00D, 0);

      // Store hit by reset in its ACCESS cycle.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h30; req_wdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_acc_dm_we", dm_we, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_acc_dm_we_gated", dm_we, 1'b0);
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      chk("midrst_write_count", wr_count, exp_wr);
      rst = 1'b0;
      do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);
      chk("const_ld_unwritten", last_rdata, 32'h0);

      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);

      for (int n = 0; n < 80; n++) begin
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, NBYTES - 1));
         if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(AW + 2, 31));
         do_req($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a, $urandom,
                int'($urandom_range(0, 2)));
      end

      for (int w = 0; w < NWORDS; w++)
         chk("final_mem", dm_mem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
